// File: rtl/tx_channel_scheduler.sv
// Round-robin TX channel scheduler: grants one channel at a time and mirrors the host
// serial line onto that channel's open-drain enable. Optional hold limit: TXSCHED_HOLD_LIMIT_EN.
module tx_channel_scheduler #(
    parameter int NCH       = 22,
    parameter int IDLE_CYC  = 160,
    parameter int START_TO  = 4096,
    parameter int GUARD_CYC = 16,
    parameter int MAX_HOLD  = 65535
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN,
    input  logic [NCH-1:0] REQ,
    output logic [NCH-1:0] GRANT,
    output logic [NCH-1:0] OUT_EN,
    output logic           BUSY,
    output logic           ABORT,
    output logic           LED
);
    localparam int          IW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [15:0] START_LAST = 16'(START_TO - 1);
    localparam logic [15:0] IDLE_LIM   = 16'(IDLE_CYC);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAITSTART, ACTIVE, GUARD} state_t;

    state_t         state_q, state_d;
    logic [1:0]     rst_sync_q, rst_sync_d;
    logic           rst_ni;
    logic           in_meta_q, in_meta_d, ins_q, ins_d;
    logic [15:0]    cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]  rr_q, rr_d, gidx_q, gidx_d, win_idx;
    logic           win_found;
    logic [NCH-1:0] grant_q, grant_d, out_en_q, out_en_d;
    logic           busy_q, busy_d, led_q, led_d;
`ifdef TXSCHED_HOLD_LIMIT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
    logic [15:0]    hold_q, hold_d;
    logic           abort_q, abort_d;
`endif

    // Reset asserts at once but releases on CLK, so the FSM never sees a runt release.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_ni = rst_sync_q[1];

    assign in_meta_d = IN;
    assign ins_d     = in_meta_q;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!win_found && REQ[IW'((int'(rr_q) + i) % NCH)]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_q) + i) % NCH);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
`ifdef TXSCHED_HOLD_LIMIT_EN
        hold_d  = hold_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = WAITSTART;
                    gidx_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_d             = (int'(win_idx) == NCH - 1) ? '0 : win_idx + 1'b1;
                end
            end
            WAITSTART: begin
                // A start bit beats a simultaneous timeout or request drop.
                if (!ins_q)                                   state_d = ACTIVE;
                else if (!REQ[gidx_q] || cnt_q >= START_LAST) state_d = GUARD;
                else                                          cnt_d   = cnt_inc;
            end
            ACTIVE: begin
                cnt_d = ins_q ? cnt_inc : '0;
                if (ins_q && cnt_inc >= IDLE_LIM) state_d = GUARD;
`ifdef TXSCHED_HOLD_LIMIT_EN
                else if (hold_q >= HOLD_LAST) begin
                    state_d = GUARD;
                    abort_d = 1'b1;
                end
                hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
`endif
            end
            GUARD: begin
                if (cnt_q >= GUARD_LAST) state_d = IDLE;
                else                     cnt_d   = cnt_inc;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
`ifdef TXSCHED_HOLD_LIMIT_EN
            hold_d = '0;
`endif
        end
        if (state_d != WAITSTART && state_d != ACTIVE) grant_d = '0;
        out_en_d = (state_d == ACTIVE && !ins_q) ? grant_d : '0;
        busy_d   = (state_d != IDLE);
        led_d    = (state_d != ACTIVE);
    end

    always_ff @(posedge CLK or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            in_meta_q <= 1'b1;
            ins_q     <= 1'b1;
            cnt_q     <= '0;
            rr_q      <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            out_en_q  <= '0;
            busy_q    <= 1'b0;
            led_q     <= 1'b1;
`ifdef TXSCHED_HOLD_LIMIT_EN
            hold_q    <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            in_meta_q <= in_meta_d;
            ins_q     <= ins_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            out_en_q  <= out_en_d;
            busy_q    <= busy_d;
            led_q     <= led_d;
`ifdef TXSCHED_HOLD_LIMIT_EN
            hold_q    <= hold_d;
            abort_q   <= abort_d;
`endif
        end
    end

    assign GRANT  = grant_q;
    assign OUT_EN = out_en_q;
    assign BUSY   = busy_q;
    assign LED    = led_q;
`ifdef TXSCHED_HOLD_LIMIT_EN
    assign ABORT  = abort_q;
`else
    assign ABORT  = 1'b0;
`endif
endmodule

// File: tb/tb_tx_channel_scheduler.sv
// Bench for tx_channel_scheduler: grant scoreboard, vector table of arbitration cases,
// and hand-timed sequences for latency, timeout, reset and hold-limit corners.
module tb_tx_channel_scheduler;
    localparam int NCH = 22;

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic           IN    = 1'b1;
    logic [NCH-1:0] REQ   = '0;
    logic [NCH-1:0] GRANT, OUT_EN;
    logic           BUSY, ABORT, LED;

    int             n_pass = 0;
    int             n_tot  = 0;
    logic [NCH-1:0] exp_q[$];
    logic [NCH-1:0] grant_prev = '0;

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] exp;
        int             nlow;
    } vec_t;
    vec_t tbl[10];

    tx_channel_scheduler #(
        .NCH(NCH), .IDLE_CYC(160), .START_TO(4096), .GUARD_CYC(16), .MAX_HOLD(100)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .REQ(REQ),
        .GRANT(GRANT), .OUT_EN(OUT_EN), .BUSY(BUSY), .ABORT(ABORT), .LED(LED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic timeout(input string nm);
        n_tot++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Scoreboard: every grant rise must match the oldest expected grant.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (GRANT != '0 && grant_prev == '0) begin
                chk("grant_onehot", 32'($onehot(GRANT)), 32'd1);
                if (exp_q.size() == 0) chk("grant_unexpected", 32'(GRANT), 32'd0);
                else                   chk("grant_sb", 32'(GRANT), 32'(exp_q.pop_front()));
            end
            if ($countones(OUT_EN) > 1 || (OUT_EN & ~GRANT) != '0 || (OUT_EN != '0 && LED))
                chk("outen_invariant", 32'(OUT_EN), 32'd0);
        end
        grant_prev = GRANT;
    end

    task automatic wait_grant(input string nm);
        int k = 0;
        while (GRANT == '0 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (GRANT == '0) timeout({nm, "_grant"});
    endtask

    task automatic finish_frame(input int nlow, input logic [NCH-1:0] exp, input string nm);
        int on = 0;
        IN = 1'b0;
        for (int k = 0; k < 700; k++) begin
            @(negedge CLK);
            if (k + 1 == nlow) IN = 1'b1;
            if (OUT_EN == exp) on++;
            if (k > nlow && !BUSY) break;
        end
        IN = 1'b1;
        if (BUSY) timeout({nm, "_idle"});
        chk({nm, "_outen_cycles"}, 32'(on), 32'(nlow));
    endtask

    task automatic do_frame(input logic [NCH-1:0] req, input logic [NCH-1:0] exp,
                            input int nlow, input string nm);
        REQ = req;
        exp_q.push_back(exp);
        wait_grant(nm);
        finish_frame(nlow, exp, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   k;
        logic [NCH-1:0] one = 1;

        tbl[0] = '{22'h000004, 22'h000004, 3};
        tbl[1] = '{22'h000003, 22'h000001, 1};
        tbl[2] = '{22'h000003, 22'h000002, 7};
        tbl[3] = '{22'h0C0000, 22'h040000, 5};
        tbl[4] = '{22'h0C0008, 22'h080000, 2};
        tbl[5] = '{22'h0C0008, 22'h000008, 12};
        tbl[6] = '{22'h200000, 22'h200000, 4};
        tbl[7] = '{22'h300001, 22'h000001, 6};
        tbl[8] = '{22'h300001, 22'h100000, 8};
        tbl[9] = '{22'h300001, 22'h200000, 9};

        #1 RST_N = 1'b0;
        #21;
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_outen", 32'(OUT_EN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_abort", 32'(ABORT), 32'd0);
        chk("rst_led", 32'(LED), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // Single frame on channel 2: grant latency, 3-cycle line latency, idle end, guard.
        REQ = 22'h000004;
        exp_q.push_back(22'h000004);
        @(negedge CLK);
        chk("t31_grant", 32'(GRANT), 32'h4);
        IN = 1'b0;
        for (int j = 1; j <= 190; j++) begin
            @(negedge CLK);
            if (j <= 14) chk("t31_outen", 32'(OUT_EN), (j >= 3 && j <= 12) ? 32'h4 : 32'h0);
            if (j == 10) IN = 1'b1;
            if (j == 20) REQ = '0;
            if (j == 171) chk("t31_led_active", 32'(LED), 32'd0);
            if (j == 172) begin
                chk("t31_led_guard", 32'(LED), 32'd1);
                chk("t31_grant_guard", 32'(GRANT), 32'd0);
            end
            if (j == 187) chk("t31_busy_guard", 32'(BUSY), 32'd1);
            if (j == 188) chk("t31_busy_idle", 32'(BUSY), 32'd0);
        end

        for (int i = 0; i < 10; i++) do_frame(tbl[i].req, tbl[i].exp, tbl[i].nlow, "tbl");

        for (int i = 0; i < 23; i++) do_frame('1, one << (i % 22), 2, "rr");
        REQ = '0;

        // Start timeout on channel 5 with the line left idle.
        REQ = 22'h000020;
        exp_q.push_back(22'h000020);
        seen = 1'b0;
        @(negedge CLK);
        chk("t33_grant", 32'(GRANT), 32'h20);
        for (int j = 1; j <= 4120; j++) begin
            @(negedge CLK);
            if (OUT_EN != '0) seen = 1'b1;
            if (j == 4095) chk("t33_wait_grant", 32'(GRANT), 32'h20);
            if (j == 4096) begin
                chk("t33_guard_grant", 32'(GRANT), 32'd0);
                chk("t33_guard_busy", 32'(BUSY), 32'd1);
            end
            if (j == 4100) REQ = '0;
        end
        chk("t33_outen_never", 32'(seen), 32'd0);
        chk("t33_idle", 32'(BUSY), 32'd0);

        // Request dropped during WAITSTART.
        REQ = 22'h000020;
        exp_q.push_back(22'h000020);
        @(negedge CLK);
        for (int j = 1; j <= 40; j++) begin
            @(negedge CLK);
            if (j == 10) begin
                chk("t33b_grant_held", 32'(GRANT), 32'h20);
                REQ = '0;
            end
            if (j == 11) chk("t33b_guard", 32'(GRANT), 32'd0);
            if (j == 26) chk("t33b_busy", 32'(BUSY), 32'd1);
            if (j == 27) chk("t33b_idle", 32'(BUSY), 32'd0);
        end

        // Reset mid-frame on channel 7, then pointer restarts at 0.
        REQ = 22'h000080;
        exp_q.push_back(22'h000080);
        wait_grant("t34");
        IN = 1'b0;
        k = 0;
        while (OUT_EN == '0 && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("t34_outen_on", 32'(OUT_EN), 32'h80);
        #2 RST_N = 1'b0;
        #1;
        chk("t34_rst_outen", 32'(OUT_EN), 32'd0);
        chk("t34_rst_grant", 32'(GRANT), 32'd0);
        chk("t34_rst_led", 32'(LED), 32'd1);
        chk("t34_rst_busy", 32'(BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        IN    = 1'b1;
        REQ   = 22'h000081;
        exp_q.push_back(22'h000001);
        wait_grant("t34_after");
        chk("t34_first_grant", 32'(GRANT), 32'h1);
        finish_frame(4, 22'h000001, "t34");
        REQ = '0;

        // Long frame with the line toggling every 4 cycles.
        REQ = 22'h000002;
        exp_q.push_back(22'h000002);
        wait_grant("t35");
        IN = 1'b0;
        k = 0;
        while (LED && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("t35_active", 32'(LED), 32'd0);
        for (int j = 1; j <= 110; j++) begin
            @(negedge CLK);
`ifdef TXSCHED_HOLD_LIMIT_EN
            if (j == 99) begin
                chk("t35_abort_pre", 32'(ABORT), 32'd0);
                chk("t35_led_pre", 32'(LED), 32'd0);
            end
            if (j == 100) begin
                chk("t35_abort", 32'(ABORT), 32'd1);
                chk("t35_abort_outen", 32'(OUT_EN), 32'd0);
                chk("t35_abort_led", 32'(LED), 32'd1);
            end
            if (j == 101) chk("t35_abort_pulse", 32'(ABORT), 32'd0);
`else
            if (j == 100 || j == 101 || j == 110) begin
                chk("t35_no_abort", 32'(ABORT), 32'd0);
                chk("t35_still_active", 32'(LED), 32'd0);
            end
`endif
            IN = ((j / 4) % 2) != 0;
        end
        IN  = 1'b1;
        REQ = '0;
        k = 0;
        while (BUSY && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY) timeout("t35_idle");
        chk("t35_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
